// File: rtl/pipelined_carry_adder_pkg.sv
// Shared arithmetic helpers for the pipelined carry adder: default geometry,
// per-stage bit-range mapping and signed saturation limits.
package pipelined_carry_adder_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

    // Lowest result bit handled by stage k.
    function automatic int chunk_lo(input int k, input int chunk);
        return k * chunk;
    endfunction

    function automatic logic [63:0] sat_pos_limit(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_neg_limit(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/pipelined_carry_adder_chunk.sv
// Combinational W-bit ripple slice; also exposes the carry entering its MSB
// so the last slice can form the signed overflow flag.
module adder_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         cmsb
);

    if (W == 1) begin : g_one
        assign cmsb    = ci;
        assign {co, s} = {1'b0, a} + {1'b0, b} + {1'b0, ci};
    end else begin : g_multi
        logic [W-2:0] lo;
        assign {cmsb, lo}    = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, ci};
        assign {co, s[W-1]}  = {1'b0, a[W-1]} + {1'b0, b[W-1]} + {1'b0, cmsb};
        assign s[W-2:0]      = lo;
    end

endmodule

// File: rtl/pipelined_carry_adder.sv
// Pipelined adder/subtractor: stage k resolves one CHUNK-bit slice, unprocessed
// operand slices and finished result slices travel with the beat so it exits whole.
module pipelined_carry_adder
    import pipelined_carry_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos_limit(WIDTH));
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg_limit(WIDTH));

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // op_* feed stage k; st_* sit between stage k and stage k+1.
    logic [WIDTH-1:0] op_a   [STAGES];
    logic [WIDTH-1:0] op_b   [STAGES];
    logic [WIDTH-1:0] op_s   [STAGES];
    logic             op_c   [STAGES];
    logic             op_sat [STAGES];
    logic             op_v   [STAGES];

    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic [WIDTH-1:0] st_s   [STAGES];
    logic             st_c   [STAGES];
    logic             st_sat [STAGES];
    logic             st_v   [STAGES];

    logic [WIDTH-1:0] ch_res [STAGES];
    logic             ch_co  [STAGES];
    logic             ch_msb [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = chunk_lo(k, CHUNK);
        localparam logic [WIDTH-1:0] MASK = WIDTH'((64'd1 << CHUNK) - 64'd1) << LO;

        logic [CHUNK-1:0] csum;

        if (k == 0) begin : g_in
            // Subtract is folded in here so later stages only ever add.
            assign op_a[k]   = a;
            assign op_b[k]   = sub ? ~b : b;
            assign op_s[k]   = '0;
            assign op_c[k]   = cin ^ sub;
            assign op_sat[k] = sat;
            assign op_v[k]   = in_valid;
        end else begin : g_skew
            assign op_a[k]   = st_a[k-1];
            assign op_b[k]   = st_b[k-1];
            assign op_s[k]   = st_s[k-1];
            assign op_c[k]   = st_c[k-1];
            assign op_sat[k] = st_sat[k-1];
            assign op_v[k]   = st_v[k-1];
        end

        adder_chunk #(.W(CHUNK)) u_chunk (
            .a    (op_a[k][LO +: CHUNK]),
            .b    (op_b[k][LO +: CHUNK]),
            .ci   (op_c[k]),
            .s    (csum),
            .co   (ch_co[k]),
            .cmsb (ch_msb[k])
        );

        assign ch_res[k] = (op_s[k] & ~MASK) | (WIDTH'(csum) << LO);

        if (k < STAGES - 1) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    st_v[k] <= 1'b0;
                end else if (adv) begin
                    st_v[k] <= op_v[k];
                end
                if (adv) begin
                    st_a[k]   <= op_a[k];
                    st_b[k]   <= op_b[k];
                    st_s[k]   <= ch_res[k];
                    st_c[k]   <= ch_co[k];
                    st_sat[k] <= op_sat[k];
                end
            end
        end
    end

    logic last_ovf;
    assign last_ovf = ch_co[STAGES-1] ^ ch_msb[STAGES-1];

    // The last stage writes straight into the output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else if (adv) begin
            out_valid <= op_v[STAGES-1];
            cout      <= ch_co[STAGES-1];
            overflow  <= last_ovf;
            if (op_sat[STAGES-1] && last_ovf) begin
                sum <= op_a[STAGES-1][WIDTH-1] ? SAT_NEG : SAT_POS;
            end else begin
                sum <= ch_res[STAGES-1];
            end
        end
    end

endmodule
